// File: rtl/parity_pkg.sv
// Shared definitions for the serial parity checker: FSM encoding and default widths.
package parity_pkg;

    localparam int DATA_W_DEF = 4;
    localparam int CNT_W_DEF  = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        DONE   = 2'd3
    } state_e;

endpackage

// File: rtl/serial_parity_checker_if.sv
// Frame control, serial input and result bundle of the serial parity checker.
interface serial_parity_checker_if
    import parity_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
);

    logic              InStart;
    logic              InOdd;
    logic              InValid;
    logic              InBit;
    logic              InClrCnt;
    logic [DATA_W-1:0] OutData;
    logic              OutPEC;
    logic              OutDone;
    logic              OutBusy;
    logic [CNT_W-1:0]  OutErrCnt;

    modport master (
        output InStart, InOdd, InValid, InBit, InClrCnt,
        input  OutData, OutPEC, OutDone, OutBusy, OutErrCnt
    );

    modport slave (
        input  InStart, InOdd, InValid, InBit, InClrCnt,
        output OutData, OutPEC, OutDone, OutBusy, OutErrCnt
    );

endinterface

// File: rtl/parity_sat_counter.sv
// Saturating up-counter for errored frames; a clear takes precedence over an increment.
module parity_sat_counter
    import parity_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/serial_parity_checker.sv
// Receives LSB-first serial frames followed by a parity bit, reports data, parity error and done.
module serial_parity_checker
    import parity_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic                   InClk,
    input  logic                   InRst,
    serial_parity_checker_if.slave bus
);

    localparam int IDX_W = $clog2(DATA_W);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

    state_e            state_q,  state_d;
    logic [IDX_W-1:0]  idx_q,    idx_d;
    logic              acc_q,    acc_d;
    logic              odd_q,    odd_d;
    logic [DATA_W-1:0] shreg_q,  shreg_d;
    logic [DATA_W-1:0] data_q,   data_d;
    logic              pec_q,    pec_d;
    logic              busy_q,   busy_d;
    logic              frame_err;
    logic              err_inc;

    assign frame_err = acc_q ^ bus.InBit ^ odd_q;

    // A start strobe in any state begins a fresh frame, which also aborts one in flight.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        odd_d   = odd_q;
        shreg_d = shreg_q;
        data_d  = data_q;
        pec_d   = pec_q;
        err_inc = 1'b0;

        if (bus.InStart) begin
            state_d = DATA;
            idx_d   = '0;
            acc_d   = 1'b0;
            odd_d   = bus.InOdd;
            shreg_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = IDLE;
                end
                DATA: begin
                    if (bus.InValid) begin
                        shreg_d[idx_q] = bus.InBit;
                        acc_d          = acc_q ^ bus.InBit;
                        idx_d          = idx_q + IDX_W'(1);
                        if (idx_q == IDX_LAST) begin
                            state_d = PARITY;
                        end
                    end
                end
                PARITY: begin
                    if (bus.InValid) begin
                        state_d = DONE;
                        data_d  = shreg_q;
                        pec_d   = frame_err;
                        err_inc = frame_err;
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        busy_d = (state_d == DATA) || (state_d == PARITY);
    end

    always_ff @(posedge InClk or posedge InRst) begin
        if (InRst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            acc_q   <= 1'b0;
            odd_q   <= 1'b0;
            shreg_q <= '0;
            data_q  <= '0;
            pec_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            odd_q   <= odd_d;
            shreg_q <= shreg_d;
            data_q  <= data_d;
            pec_q   <= pec_d;
            busy_q  <= busy_d;
        end
    end

    parity_sat_counter #(
        .CNT_W (CNT_W)
    ) u_err_cnt (
        .clk (InClk),
        .rst (InRst),
        .inc (err_inc),
        .clr (bus.InClrCnt),
        .cnt (bus.OutErrCnt)
    );

    assign bus.OutData = data_q;
    assign bus.OutPEC  = pec_q;
    assign bus.OutDone = (state_q == DONE);
    assign bus.OutBusy = busy_q;

endmodule
